// File: rtl/pc_redirect_ctrl_if.sv
// PC redirect control bus between ID stage, IF PC register and the controller.
// Counter ports exist only when PC_REDIRECT_CNT_EN is defined.
interface pc_redirect_ctrl_if;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        brch;
  logic [31:0] brch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        eret;
  logic        intr_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic        intr_ack;
  logic        in_isr;
  logic [31:0] epc;
`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] brch_cnt;
  logic [31:0] intr_cnt;
`endif

  modport master (
    output stall, id_valid, id_pc,
    output brch, brch_target,
    output jump, jump_target,
    output eret, intr_req,
`ifdef PC_REDIRECT_CNT_EN
    input  brch_cnt, intr_cnt,
`endif
    input  redirect, redirect_pc,
    input  flush_if, flush_id,
    input  intr_ack, in_isr, epc
  );

  modport slave (
    input  stall, id_valid, id_pc,
    input  brch, brch_target,
    input  jump, jump_target,
    input  eret, intr_req,
`ifdef PC_REDIRECT_CNT_EN
    output brch_cnt, intr_cnt,
`endif
    output redirect, redirect_pc,
    output flush_if, flush_id,
    output intr_ack, in_isr, epc
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbiter: interrupt > eret > branch > jump, owns EPC and ISR FSM.
// Optional redirect/interrupt counters under PC_REDIRECT_CNT_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] INTR_VECTOR = 32'h0000_0800,
  parameter int unsigned HOLDOFF     = 2
) (
  input logic               clk,
  input logic               rst_n,
  pc_redirect_ctrl_if.slave bus
);

  localparam int HW = (HOLDOFF > 3) ? $clog2(HOLDOFF + 1) : 2;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    ISR  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [31:0]   epc, epc_n;
  logic [HW-1:0] hcnt, hcnt_n;

  logic sel_intr, sel_eret, sel_brch, sel_jump;

  // One-hot select so the decoder below is truly unique.
  always_comb begin
    sel_intr = !bus.stall && state == RUN
             && bus.intr_req && bus.id_valid;
    sel_eret = !bus.stall && state == ISR && bus.eret;
    sel_brch = !bus.stall && !sel_intr && !sel_eret
             && bus.brch;
    sel_jump = !bus.stall && !sel_intr && !sel_eret
             && !bus.brch && bus.jump;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      epc   <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_n;
      epc   <= epc_n;
      hcnt  <= hcnt_n;
    end
  end

  always_comb begin
    state_n         = state;
    epc_n           = epc;
    hcnt_n          = hcnt;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.flush_if    = 1'b0;
    bus.flush_id    = 1'b0;
    bus.intr_ack    = 1'b0;

    // Holdoff counts down even while stalled.
    if (state == HOLD) begin
      hcnt_n = hcnt - HW'(1);
      if (hcnt <= HW'(1))
        state_n = RUN;
    end

    unique case (1'b1)
      sel_intr: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = INTR_VECTOR;
        bus.flush_if    = 1'b1;
        bus.flush_id    = 1'b1;
        bus.intr_ack    = 1'b1;
        epc_n           = bus.id_pc;
        state_n         = ISR;
      end
      sel_eret: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = epc;
        bus.flush_if    = 1'b1;
        hcnt_n          = HW'(HOLDOFF);
        state_n         = (HOLDOFF == 0) ? RUN : HOLD;
      end
      sel_brch: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = bus.brch_target;
        bus.flush_if    = 1'b1;
      end
      sel_jump: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = bus.jump_target;
        bus.flush_if    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_isr = (state == ISR);
  assign bus.epc    = epc;

`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] brch_cnt, intr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brch_cnt <= '0;
      intr_cnt <= '0;
    end else begin
      if (sel_brch || sel_jump)
        brch_cnt <= brch_cnt + 32'd1;
      if (sel_intr)
        intr_cnt <= intr_cnt + 32'd1;
    end
  end

  assign bus.brch_cnt = brch_cnt;
  assign bus.intr_cnt = intr_cnt;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl with a behavioural reference model.
// Define PC_REDIRECT_CNT_EN to also check the event counters.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_redirect_ctrl_if bus();

  pc_redirect_ctrl #(
    .INTR_VECTOR(VEC),
    .HOLDOFF(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic        redirect;
    logic [31:0] pc;
    logic        fi;
    logic        fid;
    logic        ack;
    logic        isr;
    logic [31:0] epc;
    logic [31:0] bc;
    logic [31:0] ic;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  int          m_state = 0;
  logic [31:0] m_epc = '0;
  int          m_hcnt = 0;
  logic [31:0] m_bc = '0;
  logic [31:0] m_ic = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.isr = (m_state == 1);
    e.epc = m_epc;
    e.bc  = m_bc;
    e.ic  = m_ic;
    if (!bus.stall) begin
      if (m_state == 0 && bus.intr_req && bus.id_valid) begin
        e.redirect = 1; e.pc = VEC;
        e.fi = 1; e.fid = 1; e.ack = 1;
      end else if (m_state == 1 && bus.eret) begin
        e.redirect = 1; e.pc = m_epc; e.fi = 1;
      end else if (bus.brch) begin
        e.redirect = 1; e.pc = bus.brch_target; e.fi = 1;
      end else if (bus.jump) begin
        e.redirect = 1; e.pc = bus.jump_target; e.fi = 1;
      end
    end
    return e;
  endfunction

  task automatic model_edge(input exp_t e);
    int ns;
    ns = m_state;
    if (m_state == 2) begin
      if (m_hcnt == 1) ns = 0;
      m_hcnt = m_hcnt - 1;
    end
    if (e.ack) begin
      m_epc = bus.id_pc;
      ns = 1;
      m_ic = m_ic + 1;
    end else if (e.redirect && m_state == 1 && bus.eret) begin
      ns = 2;
      m_hcnt = 2;
    end else if (e.redirect) begin
      m_bc = m_bc + 1;
    end
    m_state = ns;
  endtask

  task automatic step(input string tag,
                      input logic s, input logic v,
                      input logic [31:0] pc,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic e, input logic ir);
    exp_t x, y;
    bus.stall = s; bus.id_valid = v; bus.id_pc = pc;
    bus.brch = b; bus.brch_target = bt;
    bus.jump = j; bus.jump_target = jt;
    bus.eret = e; bus.intr_req = ir;
    x = model_out();
    q.push_back(x);
    #2;
    y = q.pop_front();
    chk({tag, ".redirect"}, 32'(bus.redirect), 32'(y.redirect));
    chk({tag, ".pc"}, bus.redirect_pc, y.pc);
    chk({tag, ".flush_if"}, 32'(bus.flush_if), 32'(y.fi));
    chk({tag, ".flush_id"}, 32'(bus.flush_id), 32'(y.fid));
    chk({tag, ".ack"}, 32'(bus.intr_ack), 32'(y.ack));
    chk({tag, ".in_isr"}, 32'(bus.in_isr), 32'(y.isr));
    chk({tag, ".epc"}, bus.epc, y.epc);
`ifdef PC_REDIRECT_CNT_EN
    chk({tag, ".brch_cnt"}, bus.brch_cnt, y.bc);
    chk({tag, ".intr_cnt"}, bus.intr_cnt, y.ic);
`endif
    @(posedge clk);
    model_edge(y);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.stall = 0; bus.id_valid = 0; bus.id_pc = 0;
    bus.brch = 0; bus.brch_target = 0;
    bus.jump = 0; bus.jump_target = 0;
    bus.eret = 0; bus.intr_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle("reset");
    step("t1_brch", 0, 1, 32'h10, 1, 32'h40, 0, 0, 0, 0);
    step("t2_stall", 1, 1, 32'h10, 1, 32'h40, 0, 0, 0, 0);
    step("t2_release", 0, 1, 32'h10, 1, 32'h40, 0, 0, 0, 0);
    step("jump", 0, 1, 32'h14, 0, 0, 1, 32'h123, 0, 0);
    step("brch_jump", 0, 1, 32'h14, 1, 32'h88, 1, 32'h99, 0, 0);
    step("eret_run", 0, 1, 32'h18, 0, 0, 1, 32'h200, 1, 0);

    step("t3_intr", 0, 1, 32'h1C, 1, 32'h40, 0, 0, 0, 1);
    step("t4_isr_held", 0, 1, 32'h800, 0, 0, 0, 0, 0, 1);
    step("t4_isr_brch", 0, 1, 32'h804, 1, 32'h900, 0, 0, 0, 1);
    step("t4_eret_stall", 1, 1, 32'h808, 0, 0, 0, 0, 1, 1);
    step("t4_eret", 0, 1, 32'h808, 1, 32'h5, 0, 0, 1, 1);
    step("t4_hold1", 0, 1, 32'h1C, 0, 0, 0, 0, 1, 1);
    step("t4_hold2", 0, 1, 32'h20, 0, 0, 0, 0, 0, 1);
    step("t4_retake", 0, 1, 32'h24, 0, 0, 0, 0, 0, 1);
    step("t4_eret2", 0, 1, 32'h800, 0, 0, 0, 0, 1, 0);
    idle("t4_drain1");
    idle("t4_drain2");

    for (int i = 0; i < 3; i++)
      step("t5_novalid", 0, 0, 32'h30, 0, 0, 0, 0, 0, 1);
    step("t5_valid", 0, 1, 32'h34, 0, 0, 0, 0, 0, 1);
    idle("t6_isr");

    rst_n = 1'b0;
    #1;
    chk("t6_rst.in_isr", 32'(bus.in_isr), 32'd0);
    chk("t6_rst.epc", bus.epc, 32'd0);
`ifdef PC_REDIRECT_CNT_EN
    chk("t6_rst.brch_cnt", bus.brch_cnt, 32'd0);
    chk("t6_rst.intr_cnt", bus.intr_cnt, 32'd0);
`endif
    m_state = 0; m_epc = '0; m_hcnt = 0;
    m_bc = '0; m_ic = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_retake", 0, 1, 32'h3C, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 3) == 0),
           1'($urandom),
           $urandom,
           ($urandom_range(0, 2) == 0),
           $urandom,
           ($urandom_range(0, 2) == 0),
           $urandom,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
